phy_tx_nlane: RTL and testbench

PHY_TX_NLANE -- requirements
Module: phy_tx_nlane

---
 rtl/phy_tx_pkg.sv | 31 +++
 rtl/phy_tx_lane.sv | 87 ++++++++
 rtl/phy_tx_nlane.sv | 85 ++++++++
 tb/tb_phy_tx_nlane.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/phy_tx_pkg.sv
// ============================================================================
// Module  : phy_tx_pkg
// Brief   : Shared widths, idle word, lane state type and LFSR helpers for
//           the multi-lane serial transmitter.
// Revision: 1.0
// ============================================================================
`default_nettype none

package phy_tx_pkg;

    localparam int WORD_W = 32;
    localparam int CNT_W  = 5;

    localparam logic [WORD_W-1:0] IDLE_WORD_DEFAULT = 32'hBCBCBCBC;

    // x^16 + x^5 + x^4 + x^3 + 1 -> state bits 15, 4, 3, 2
    localparam logic [15:0] LFSR_SEED = 16'hFFFF;
    localparam logic [15:0] LFSR_TAPS = 16'h801C;

    typedef enum logic {
        LANE_IDLE = 1'b0,
        LANE_DATA = 1'b1
    } lane_state_e;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

`default_nettype wire

// File: rtl/phy_tx_lane.sv
// ============================================================================
// Module  : phy_tx_lane
// Brief   : One serial lane: holding register, frame shift register, lane
//           state flop and, with PHY_TX_SCRAMBLE_EN defined, an additive LFSR.
// Revision: 1.0
// ============================================================================
`default_nettype none

module phy_tx_lane
    import phy_tx_pkg::*;
#(
    parameter logic [WORD_W-1:0] IDLE_WORD = IDLE_WORD_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en_i,
    input  logic [WORD_W-1:0] data_i,
    input  logic              load_i,
    output logic              hold_full_o,
    output logic              serial_o,
    output logic              lane_valid_o
);

    logic [WORD_W-1:0] hold_q, hold_d;
    logic              full_q, full_d;
    logic [WORD_W-1:0] shift_q, shift_d;
    lane_state_e       state_q, state_d;

    // Load decision uses the pre-edge full flag; a write landing on the
    // boundary edge therefore waits for the following frame.
    always_comb begin
        hold_d  = hold_q;
        full_d  = full_q;
        shift_d = {shift_q[WORD_W-2:0], 1'b0};
        state_d = state_q;
        if (load_i) begin
            if (full_q) begin
                shift_d = hold_q;
                full_d  = 1'b0;
                state_d = LANE_DATA;
            end else begin
                shift_d = IDLE_WORD;
                state_d = LANE_IDLE;
            end
        end
        if (wr_en_i) begin
            hold_d = data_i;
            full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_q  <= '0;
            full_q  <= 1'b0;
            shift_q <= IDLE_WORD;
            state_q <= LANE_IDLE;
        end else begin
            hold_q  <= hold_d;
            full_q  <= full_d;
            shift_q <= shift_d;
            state_q <= state_d;
        end
    end

    assign hold_full_o  = full_q;
    assign lane_valid_o = (state_q == LANE_DATA);

`ifdef PHY_TX_SCRAMBLE_EN
    logic [15:0] lfsr_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_next(lfsr_q);
        end
    end

    assign serial_o = shift_q[WORD_W-1] ^ lfsr_q[15];
`else
    assign serial_o = shift_q[WORD_W-1];
`endif

endmodule

`default_nettype wire

// File: rtl/phy_tx_nlane.sv
// ============================================================================
// Module  : phy_tx_nlane
// Brief   : Round-robin word striper over LANES frame-aligned serial lanes.
//           Optional per-lane scrambling via macro PHY_TX_SCRAMBLE_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module phy_tx_nlane
    import phy_tx_pkg::*;
#(
    parameter int                LANES     = 2,
    parameter logic [WORD_W-1:0] IDLE_WORD = IDLE_WORD_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WORD_W-1:0] input_bus,
    input  logic              valid,
    output logic              ready,
    output logic [LANES-1:0]  serial_o,
    output logic [LANES-1:0]  lane_valid_o,
    output logic              frame_start_o
);

    localparam int               PTR_W    = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(LANES - 1);

    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [LANES-1:0] hold_full;
    logic [LANES-1:0] wr_en;
    logic             load;

    assign load          = (bit_cnt_q == LAST_BIT);
    assign frame_start_o = (bit_cnt_q == '0);

    // Ready depends only on the addressed lane's flop, never on valid.
    always_comb begin
        ready = 1'b0;
        wr_en = '0;
        for (int k = 0; k < LANES; k++) begin
            if (ptr_q == PTR_W'(k)) begin
                ready    = !hold_full[k];
                wr_en[k] = valid && !hold_full[k];
            end
        end
    end

    always_comb begin
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
        ptr_d     = ptr_q;
        if (valid && ready) begin
            ptr_d = (ptr_q == LAST_PTR) ? '0 : ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt_q <= '0;
            ptr_q     <= '0;
        end else begin
            bit_cnt_q <= bit_cnt_d;
            ptr_q     <= ptr_d;
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        phy_tx_lane #(
            .IDLE_WORD (IDLE_WORD)
        ) u_lane (
            .clk          (clk),
            .reset        (reset),
            .wr_en_i      (wr_en[k]),
            .data_i       (input_bus),
            .load_i       (load),
            .hold_full_o  (hold_full[k]),
            .serial_o     (serial_o[k]),
            .lane_valid_o (lane_valid_o[k])
        );
    end

endmodule

`default_nettype wire

// File: tb/tb_phy_tx_nlane.sv
// ============================================================================
// Module  : tb_phy_tx_nlane
// Brief   : Self-checking bench for phy_tx_nlane with a frame-level reference
//           model (default build, PHY_TX_SCRAMBLE_EN undefined).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_phy_tx_nlane;

    localparam int          LANES = 2;
    localparam logic [31:0] IDLE  = 32'hBCBCBCBC;

    logic              clk = 1'b0;
    logic              reset;
    logic [31:0]       input_bus;
    logic              valid;
    logic              ready;
    logic [LANES-1:0]  serial_o;
    logic [LANES-1:0]  lane_valid_o;
    logic              frame_start_o;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    phy_tx_nlane #(
        .LANES     (LANES),
        .IDLE_WORD (IDLE)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .input_bus     (input_bus),
        .valid         (valid),
        .ready         (ready),
        .serial_o      (serial_o),
        .lane_valid_o  (lane_valid_o),
        .frame_start_o (frame_start_o)
    );

    // Frame-level model: each lane owns a pending slot and the word of the
    // frame in flight; the bit on the wire is that word indexed by position.
    int          m_bit;
    int          m_ptr;
    bit          m_full  [LANES];
    logic [31:0] m_hold  [LANES];
    logic [31:0] m_frame [LANES];
    bit          m_fv    [LANES];

    function automatic logic [2*LANES+1:0] model_outs();
        logic [LANES-1:0] s, lv;
        for (int k = 0; k < LANES; k++) begin
            s[k]  = m_frame[k][31-m_bit];
            lv[k] = m_fv[k];
        end
        return {!m_full[m_ptr], (m_bit == 0), lv, s};
    endfunction

    task automatic model_reset();
        m_bit = 0;
        m_ptr = 0;
        for (int k = 0; k < LANES; k++) begin
            m_full[k]  = 0;
            m_hold[k]  = '0;
            m_frame[k] = IDLE;
            m_fv[k]    = 0;
        end
    endtask

    task automatic tick();
        bit          xfer;
        logic [31:0] d;
        xfer = valid && !m_full[m_ptr];
        d    = input_bus;
        @(posedge clk);
        if (m_bit == 31) begin
            for (int k = 0; k < LANES; k++) begin
                m_frame[k] = m_full[k] ? m_hold[k] : IDLE;
                m_fv[k]    = m_full[k];
                m_full[k]  = 0;
            end
        end
        if (xfer) begin
            m_hold[m_ptr] = d;
            m_full[m_ptr] = 1;
            m_ptr         = (m_ptr + 1) % LANES;
        end
        m_bit = (m_bit + 1) % 32;
        @(negedge clk);
    endtask

    task automatic assert_reset();
        reset = 1'b1;
        valid = 1'b0;
        model_reset();
        #1;
    endtask

    task automatic release_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        assert_reset();
        tests_run++;
        if (ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_ready: got %b want 1", ready);
        end
        tests_run++;
        if (frame_start_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_frame_start: got %b want 1", frame_start_o);
        end
        tests_run++;
        if (lane_valid_o !== '0) begin
            tests_failed++;
            $display("FAIL reset_lane_valid: got %b want 0", lane_valid_o);
        end
        tests_run++;
        if (serial_o !== {LANES{1'b1}}) begin
            tests_failed++;
            $display("FAIL reset_serial: got %b want all 1", serial_o);
        end
        release_reset();
    endtask

    task automatic test_idle();
        logic [31:0] iw;
        iw = IDLE;
        for (int c = 0; c < 64; c++) begin
            tests_run++;
            if ({ready, frame_start_o, lane_valid_o, serial_o} !== model_outs()) begin
                tests_failed++;
                $display("FAIL idle_model c=%0d: got %b want %b", c,
                         {ready, frame_start_o, lane_valid_o, serial_o}, model_outs());
            end
            tests_run++;
            if (serial_o !== {LANES{iw[31-(c%32)]}} || lane_valid_o !== '0 ||
                frame_start_o !== ((c % 32) == 0)) begin
                tests_failed++;
                $display("FAIL idle_pattern c=%0d: got ser=%b lv=%b fs=%b want ser bit %b lv=0 fs=%b",
                         c, serial_o, lane_valid_o, frame_start_o, iw[31-(c%32)], ((c % 32) == 0));
            end
            tick();
        end
    endtask

    task automatic test_directed();
        logic [31:0] w0, w1;
        assert_reset();
        release_reset();
        w0 = '0;
        w1 = '0;
        for (int i = 0; i < 96; i++) begin
            valid     = (i < 2);
            input_bus = (i == 0) ? 32'hDEADBEEF : 32'h12345678;
            tests_run++;
            if ({ready, frame_start_o, lane_valid_o, serial_o} !== model_outs()) begin
                tests_failed++;
                $display("FAIL directed_model i=%0d: got %b want %b", i,
                         {ready, frame_start_o, lane_valid_o, serial_o}, model_outs());
            end
            if (i >= 32 && i < 64) begin
                w0 = {w0[30:0], serial_o[0]};
                w1 = {w1[30:0], serial_o[1]};
                tests_run++;
                if (lane_valid_o !== 2'b11) begin
                    tests_failed++;
                    $display("FAIL directed_lane_valid i=%0d: got %b want 11", i, lane_valid_o);
                end
            end
            tick();
        end
        valid = 1'b0;
        tests_run++;
        if (w0 !== 32'hDEADBEEF) begin
            tests_failed++;
            $display("FAIL directed_lane0_word: got %h want deadbeef", w0);
        end
        tests_run++;
        if (w1 !== 32'h12345678) begin
            tests_failed++;
            $display("FAIL directed_lane1_word: got %h want 12345678", w1);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] q[$];
        logic [31:0] acc [LANES];
        logic [31:0] exp_w;
        int          popped;
        bit          took;
        assert_reset();
        release_reset();
        popped    = 0;
        valid     = 1'b1;
        input_bus = $urandom;
        for (int c = 0; c < 224; c++) begin
            tests_run++;
            if ({ready, frame_start_o, lane_valid_o, serial_o} !== model_outs()) begin
                tests_failed++;
                $display("FAIL b2b_model c=%0d: got %b want %b", c,
                         {ready, frame_start_o, lane_valid_o, serial_o}, model_outs());
            end
            if (c == LANES) begin
                tests_run++;
                if (ready !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL b2b_ready_drop: got %b want 0", ready);
                end
            end
            for (int k = 0; k < LANES; k++) acc[k] = {acc[k][30:0], serial_o[k]};
            if ((c % 32) == 31) begin
                for (int k = 0; k < LANES; k++) begin
                    if (lane_valid_o[k]) begin
                        exp_w = (q.size() > 0) ? q.pop_front() : 32'hxxxxxxxx;
                        popped++;
                        tests_run++;
                        if (acc[k] !== exp_w) begin
                            tests_failed++;
                            $display("FAIL b2b_order c=%0d lane=%0d: got %h want %h", c, k, acc[k], exp_w);
                        end
                    end
                end
            end
            took = ready;
            if (took) q.push_back(input_bus);
            tick();
            if (took) input_bus = $urandom;
        end
        valid = 1'b0;
        tests_run++;
        if (popped != 6 * LANES) begin
            tests_failed++;
            $display("FAIL b2b_throughput: got %0d words want %0d", popped, 6 * LANES);
        end
    endtask

    task automatic test_write_at_31();
        logic [31:0] w;
        assert_reset();
        release_reset();
        for (int c = 0; c < 31; c++) tick();
        w         = $urandom;
        valid     = 1'b1;
        input_bus = w;
        tests_run++;
        if (ready !== 1'b1 || frame_start_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL wr31_ready: got ready=%b fs=%b want ready=1 fs=0", ready, frame_start_o);
        end
        tick();
        valid = 1'b0;
        for (int i = 1; i <= 33; i++) begin
            tests_run++;
            if ({ready, frame_start_o, lane_valid_o, serial_o} !== model_outs()) begin
                tests_failed++;
                $display("FAIL wr31_model i=%0d: got %b want %b", i,
                         {ready, frame_start_o, lane_valid_o, serial_o}, model_outs());
            end
            tests_run++;
            if (i <= 32 && lane_valid_o[0] !== 1'b0) begin
                tests_failed++;
                $display("FAIL wr31_idle_frame i=%0d: got lv0=%b want 0", i, lane_valid_o[0]);
            end else if (i == 33 && (lane_valid_o[0] !== 1'b1 || serial_o[0] !== w[31])) begin
                tests_failed++;
                $display("FAIL wr31_first_bit: got lv0=%b bit=%b want lv0=1 bit=%b",
                         lane_valid_o[0], serial_o[0], w[31]);
            end
            tick();
        end
    endtask

    task automatic test_reset_midframe();
        logic [31:0] w, acc;
        assert_reset();
        release_reset();
        for (int c = 0; c < 17; c++) begin
            valid     = (c < 2);
            input_bus = $urandom;
            tick();
        end
        valid = 1'b0;
        tests_run++;
        if (ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrst_full_before: got ready=%b want 0", ready);
        end
        assert_reset();
        tests_run++;
        if (ready !== 1'b1 || lane_valid_o !== '0 || frame_start_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL midrst_during: got ready=%b lv=%b fs=%b want 1 0 1",
                     ready, lane_valid_o, frame_start_o);
        end
        release_reset();
        w   = $urandom;
        acc = '0;
        for (int c = 0; c < 64; c++) begin
            valid     = (c == 0);
            input_bus = w;
            tests_run++;
            if ({ready, frame_start_o, lane_valid_o, serial_o} !== model_outs()) begin
                tests_failed++;
                $display("FAIL midrst_model c=%0d: got %b want %b", c,
                         {ready, frame_start_o, lane_valid_o, serial_o}, model_outs());
            end
            if (c >= 32) acc = {acc[30:0], serial_o[0]};
            tests_run++;
            if (lane_valid_o !== ((c < 32) ? 2'b00 : 2'b01)) begin
                tests_failed++;
                $display("FAIL midrst_lane_valid c=%0d: got %b want %b", c, lane_valid_o,
                         (c < 32) ? 2'b00 : 2'b01);
            end
            tick();
        end
        tests_run++;
        if (acc !== w) begin
            tests_failed++;
            $display("FAIL midrst_lane0_word: got %h want %h", acc, w);
        end
    endtask

    task automatic test_random();
        assert_reset();
        release_reset();
        for (int c = 0; c < 480; c++) begin
            valid     = ($urandom_range(0, 3) != 0);
            input_bus = $urandom;
            tests_run++;
            if ({ready, frame_start_o, lane_valid_o, serial_o} !== model_outs()) begin
                tests_failed++;
                $display("FAIL random_model c=%0d: got %b want %b", c,
                         {ready, frame_start_o, lane_valid_o, serial_o}, model_outs());
            end
            tick();
        end
        valid = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        valid     = 1'b0;
        input_bus = '0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_idle();
        test_directed();
        test_back_to_back();
        test_write_at_31();
        test_reset_midframe();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

`default_nettype wire
